// File: rtl/digit_serial_adder.sv
// Digit-serial adder/subtractor: one DIGIT-bit slice per cycle,
// carry held in a register between slices, start/busy/done handshake.
module digit_serial_adder #(
   parameter int WIDTH = 16,
   parameter int DIGIT = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int STEPS = WIDTH / DIGIT;
   localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t           state;
   state_t           state_next;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] acc;
   logic             carry;
   logic [CW-1:0]    cnt;

   logic [DIGIT:0]   slice;
   logic [WIDTH-1:0] slice_ext;
   logic [WIDTH-1:0] acc_next;
   logic             msb_cin;
   logic             last;

   // Slice adder; carry into the slice MSB recovered from its sum bit.
   always_comb begin
      slice = {1'b0, a_sh[DIGIT-1:0]}
            + {1'b0, b_sh[DIGIT-1:0]}
            + {{DIGIT{1'b0}}, carry};
      msb_cin = a_sh[DIGIT-1] ^ b_sh[DIGIT-1]
              ^ slice[DIGIT-1];
      slice_ext = WIDTH'(slice[DIGIT-1:0]);
      acc_next = (acc >> DIGIT)
               | (slice_ext << (WIDTH - DIGIT));
      last = (state == S_RUN)
          && (cnt == CW'(STEPS - 1));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      busy       = 1'b0;
      done       = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (start) state_next = S_RUN;
         end
         S_RUN: begin
            busy = 1'b1;
            if (last) state_next = S_DONE;
         end
         S_DONE: begin
            done       = 1'b1;
            state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         a_sh  <= '0;
         b_sh  <= '0;
         acc   <= '0;
         carry <= 1'b0;
         cnt   <= '0;
         sum   <= '0;
         cout  <= 1'b0;
         ovf   <= 1'b0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (start) begin
                  a_sh  <= a;
                  b_sh  <= sub ? ~b : b;
                  carry <= sub ? 1'b1 : cin;
                  cnt   <= '0;
               end
            end
            S_RUN: begin
               a_sh  <= a_sh >> DIGIT;
               b_sh  <= b_sh >> DIGIT;
               acc   <= acc_next;
               carry <= slice[DIGIT];
               cnt   <= cnt + CW'(1);
               if (last) begin
                  sum  <= acc_next;
                  cout <= slice[DIGIT];
                  ovf  <= msb_cin ^ slice[DIGIT];
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_digit_serial_adder.sv
// Bench for digit_serial_adder: six parameterisations driven in
// lockstep, directed vectors plus random sweep vs arithmetic model.
module tb_digit_serial_adder;

   localparam int N = 6;

   function automatic int wof(input int i);
      return (i == 5) ? 8 : 16;
   endfunction

   function automatic int dof(input int i);
      case (i)
         0: return 4;
         1: return 1;
         2: return 2;
         3: return 8;
         4: return 16;
         default: return 8;
      endcase
   endfunction

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        sub;
   logic        cin;
   logic [15:0] a;
   logic [15:0] b;

   logic [N-1:0] busy_v;
   logic [N-1:0] done_v;
   logic [N-1:0] cout_v;
   logic [N-1:0] ovf_v;
   logic [15:0]  sum_v [N];

   int errors = 0;
   int checks = 0;
   int lat [N];
   int busy_cnt;
   int overlap;

   always #5 clk = ~clk;

   for (genvar i = 0; i < N; i++) begin : g
      localparam int W = wof(i);
      localparam int D = dof(i);
      logic [W-1:0] s;
      logic bz, dn, co, ov;
      digit_serial_adder #(.WIDTH(W), .DIGIT(D)) dut (
         .clk   (clk),
         .reset (reset),
         .start (start),
         .sub   (sub),
         .a     (a[W-1:0]),
         .b     (b[W-1:0]),
         .cin   (cin),
         .busy  (bz),
         .done  (dn),
         .sum   (s),
         .cout  (co),
         .ovf   (ov)
      );
      assign busy_v[i] = bz;
      assign done_v[i] = dn;
      assign cout_v[i] = co;
      assign ovf_v[i]  = ov;
      assign sum_v[i]  = 16'(s);
   end

   typedef struct {
      logic        sub;
      logic [15:0] a;
      logic [15:0] b;
      logic        cin;
      logic [15:0] sum;
      logic        cout;
      logic        ovf;
   } vec_t;

   vec_t tbl [6];

   task automatic chk(input string nm,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
      end
   endtask

   // Reference: plain wide arithmetic, masked to w bits.
   function automatic logic [17:0] model(input int w,
                                         input logic s,
                                         input logic [15:0] aa,
                                         input logic [15:0] bb,
                                         input logic c);
      logic [16:0] m, ae, be, full;
      logic sa, sb, sr, co, ov;
      m    = (17'd1 << w) - 17'd1;
      ae   = {1'b0, aa} & m;
      be   = (s ? {1'b0, ~bb} : {1'b0, bb}) & m;
      full = ae + be + ((s || c) ? 17'd1 : 17'd0);
      sa   = ae[w-1];
      sb   = be[w-1];
      sr   = full[w-1];
      co   = full[w];
      ov   = (sa == sb) && (sr != sa);
      return {ov, co, full[15:0] & m[15:0]};
   endfunction

   task automatic run_op(input logic s, input logic [15:0] aa,
                         input logic [15:0] bb, input logic c);
      @(negedge clk);
      sub   = s;
      a     = aa;
      b     = bb;
      cin   = c;
      start = 1'b1;
      for (int i = 0; i < N; i++) lat[i] = -1;
      busy_cnt = 0;
      overlap  = 0;
      @(posedge clk);
      #1;
      start = 1'b0;
      for (int n = 0; n <= 20; n++) begin
         if (n > 0) begin
            @(posedge clk);
            #1;
         end
         if (busy_v[0]) busy_cnt++;
         if (busy_v[0] && done_v[0]) overlap++;
         for (int i = 0; i < N; i++)
            if (done_v[i] && lat[i] < 0) lat[i] = n;
      end
   endtask

   task automatic check_all(input logic s, input logic [15:0] aa,
                            input logic [15:0] bb, input logic c);
      logic [17:0] e;
      for (int i = 0; i < N; i++) begin
         e = model(wof(i), s, aa, bb, c);
         chk($sformatf("sum[%0d]", i), 32'(sum_v[i]), 32'(e[15:0]));
         chk($sformatf("cout[%0d]", i), 32'(cout_v[i]), 32'(e[16]));
         chk($sformatf("ovf[%0d]", i), 32'(ovf_v[i]), 32'(e[17]));
         chk($sformatf("lat[%0d]", i), 32'(lat[i]),
             32'(wof(i) / dof(i)));
      end
   endtask

   initial begin
      tbl[0] = '{1'b0, 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
      tbl[1] = '{1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
      tbl[2] = '{1'b0, 16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0, 1'b1};
      tbl[3] = '{1'b1, 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0};
      tbl[4] = '{1'b1, 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1};
      tbl[5] = '{1'b0, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};

      reset = 1'b1;
      start = 1'b0;
      sub   = 1'b0;
      cin   = 1'b0;
      a     = '0;
      b     = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", 32'(busy_v), 32'd0);
      chk("rst_done", 32'(done_v), 32'd0);
      chk("rst_sum0", 32'(sum_v[0]), 32'd0);
      chk("rst_cout", 32'(cout_v), 32'd0);
      chk("rst_ovf", 32'(ovf_v), 32'd0);
      @(negedge clk);
      reset = 1'b0;

      // Directed table against all 16-bit instances
      foreach (tbl[t]) begin
         run_op(tbl[t].sub, tbl[t].a, tbl[t].b, tbl[t].cin);
         for (int i = 0; i < 5; i++) begin
            chk($sformatf("tbl%0d_sum[%0d]", t, i),
                32'(sum_v[i]), 32'(tbl[t].sum));
            chk($sformatf("tbl%0d_cout[%0d]", t, i),
                32'(cout_v[i]), 32'(tbl[t].cout));
            chk($sformatf("tbl%0d_ovf[%0d]", t, i),
                32'(ovf_v[i]), 32'(tbl[t].ovf));
         end
         chk($sformatf("tbl%0d_lat", t), 32'(lat[0]), 32'd4);
         chk($sformatf("tbl%0d_busy", t), 32'(busy_cnt), 32'd4);
         chk($sformatf("tbl%0d_overlap", t), 32'(overlap), 32'd0);
      end

      // Starts during RUN and DONE are ignored
      @(negedge clk);
      sub = 1'b0; a = 16'h1234; b = 16'h4321; cin = 1'b0;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      @(posedge clk);
      #1;
      a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("hs_done", 32'(done_v[0]), 32'd1);
      chk("hs_sum", 32'(sum_v[0]), 32'h5555);
      a = 16'h0F0F; b = 16'h0101; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      chk("hs_idle_busy", 32'(busy_v[0]), 32'd0);
      @(posedge clk);
      #1;
      chk("hs_idle_busy2", 32'(busy_v[0]), 32'd0);
      chk("hs_sum_hold", 32'(sum_v[0]), 32'h5555);
      repeat (20) @(posedge clk);

      // Reset mid-operation discards it
      @(negedge clk);
      a = 16'h1111; b = 16'h2222; sub = 1'b0; cin = 1'b0;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      chk("mid_rst_busy", 32'(busy_v[0]), 32'd0);
      chk("mid_rst_sum", 32'(sum_v[0]), 32'd0);
      chk("mid_rst_cout", 32'(cout_v[0]), 32'd0);
      chk("mid_rst_ovf", 32'(ovf_v[0]), 32'd0);
      overlap = 0;
      for (int n = 0; n < 8; n++) begin
         @(posedge clk);
         #1;
         if (done_v[0] || busy_v[0]) overlap++;
      end
      chk("mid_rst_quiet", 32'(overlap), 32'd0);

      // Reset wins over start in the same cycle
      @(negedge clk);
      reset = 1'b1;
      start = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_prio_busy", 32'(busy_v[0]), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      start = 1'b0;

      run_op(1'b0, 16'h0F0F, 16'h0101, 1'b1);
      check_all(1'b0, 16'h0F0F, 16'h0101, 1'b1);

      // Random sweep across all parameterisations
      for (int k = 0; k < 1000; k++) begin
         logic        rs, rc;
         logic [15:0] ra, rb;
         rs = 1'($urandom);
         rc = 1'($urandom);
         ra = 16'($urandom);
         rb = 16'($urandom);
         run_op(rs, ra, rb, rc);
         check_all(rs, ra, rb, rc);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
